rr_arb4: RTL
============

RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the bit width of each requester data word and of out_data.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req_valid, input, 4 bits: bit i set means requester i offers a word.
REQ-005 The block SHALL have port req_data0..req_data3, input, WIDTH bits each: the requester words.
REQ-006 The block SHALL have port req_ready, output, 4 bits: bit i set means requester i's word is accepted this cycle.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_data holds an undelivered word.
REQ-008 The block SHALL have port out_data, output, WIDTH bits: the registered granted word.
REQ-009 The block SHALL have port out_sel, output, 2 bits: index of the requester whose word is in out_data.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes out_data this cycle when out_valid is also set.

Function
REQ-011 The block SHALL use two states: IDLE, with no word held, and BUSY, with a word held.
REQ-012 The block SHALL define accept = (state==IDLE or out_ready) and req_valid != 0.
REQ-013 The winner SHALL be the first requester with req_valid set, scanning from (ptr+1) mod 4 upward with wrap-around.
REQ-014 req_ready SHALL be combinational and one-hot at the winner when accept is true, and all-zero otherwise.
REQ-015 On an accept edge, the block SHALL register out_data = req_data[winner], out_sel = winner, ptr = winner, and enter BUSY.
REQ-016 Latency SHALL be one cycle: the accepted word is visible on out_data with out_valid=1 on the next cycle.
REQ-017 In BUSY without out_ready, out_valid, out_data and out_sel SHALL hold stable and req_ready SHALL be 0.
REQ-018 In BUSY with out_ready and req_valid != 0, the block SHALL accept a new winner in the same cycle and stay BUSY, giving back-to-back throughput of one word per cycle.
REQ-019 In BUSY with out_ready and req_valid == 0, the block SHALL go to IDLE and drive out_valid=0 on the next cycle.
REQ-020 In IDLE with req_valid == 0, the block SHALL hold all state.
REQ-021 out_valid SHALL be 1 exactly when the state is BUSY.
REQ-022 A requester dropping req_valid before it is granted SHALL simply be skipped, with no error and no state change.
REQ-023 With all four requesters continuously valid, the block SHALL grant them in the strict order 0,1,2,3,0,... with no requester starved.

Reset
REQ-024 When rst is sampled high, the block SHALL go to IDLE with out_valid=0, out_data=0, out_sel=0 and ptr=3, so requester 0 has first priority.
REQ-025 rst SHALL override any accept in the same cycle, and req_ready SHALL be 0 while rst is high.
REQ-026 Reset asserted while BUSY SHALL discard the held word, which is never delivered.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, BUSY), NUM_REQ=4 and SEL_W=2.
REQ-028 Data selection SHALL instantiate the existing mux4 sub-module, with d0..d3=req_data0..3, sel=winner, and its output feeding the out_data register.
REQ-029 Priority rotation SHALL be pure combinational logic from ptr and req_valid, with no additional sub-module.

Verification
REQ-030 Reset check: assert rst for 2 cycles, then release -> out_valid=0, out_data=0, out_sel=0 and req_ready=0000.
REQ-031 Single request: req_valid=0100, req_data2=0xA5, out_ready=0 -> req_ready=0100 for one cycle, then out_valid=1, out_sel=2, out_data=0xA5, held stable for 5 cycles.
REQ-032 Fairness: req_valid=1111, req_dataN=N+1, out_ready=1 -> out_sel sequence 0,1,2,3,0 and out_data sequence 1,2,3,4,1 on consecutive cycles.
REQ-033 Backpressure: BUSY with out_sel=1 while req_valid=1001 and out_ready=0 for 3 cycles -> req_ready=0000 throughout; when out_ready=1, the next grant is requester 3.
REQ-034 Drain to idle: BUSY, out_ready=1, req_valid=0000 -> out_valid=0 on the next cycle, and a later req_valid=0001 is granted with one-cycle latency.
REQ-035 Mid-operation reset: BUSY with out_data=0x1234, rst pulsed for 1 cycle -> out_valid=0 and out_data=0; with all requesters valid afterwards, the first grant is requester 0.

Source files
------------

// File: rtl/rr_arb4_pkg.sv
// Shared types and sizes for the 4-way round-robin arbiter.
package rr_arb4_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    // IDLE: no word held; BUSY: out_data holds an undelivered word.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mux4.sv
// Four-input word multiplexer.
module mux4 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    // Select one of the four inputs.
    always_comb begin
        y = d0;
        unique case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
        endcase
    end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with a single registered output slot.
module rr_arb4
    import rr_arb4_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [WIDTH-1:0]   req_data0,
    input  logic [WIDTH-1:0]   req_data1,
    input  logic [WIDTH-1:0]   req_data2,
    input  logic [WIDTH-1:0]   req_data3,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [WIDTH-1:0]   data_q, data_d;

    logic [SEL_W-1:0]   winner;
    logic [SEL_W-1:0]   idx;
    logic               found;
    logic               accept;
    logic [WIDTH-1:0]   mux_out;

    // Scan requesters starting just after the last winner, wrapping modulo 4.
    always_comb begin
        winner = ptr_q;
        idx    = ptr_q;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = ptr_q + SEL_W'(k);
            if (!found && req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // The slot can take a word when empty or being emptied this cycle.
    always_comb begin
        accept = ((state_q == IDLE) || out_ready) && found;
        // Reset wins over any grant, so nothing is acknowledged while rst is high.
        req_ready = (accept && !rst) ? (NUM_REQ'(1) << winner) : '0;
    end

    mux4 #(
        .WIDTH (WIDTH)
    ) u_mux4 (
        .d0  (req_data0),
        .d1  (req_data1),
        .d2  (req_data2),
        .d3  (req_data3),
        .sel (winner),
        .y   (mux_out)
    );

    // Next-state: load a new winner, drain to idle, or hold.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        if (accept) begin
            state_d = BUSY;
            ptr_d   = winner;
            sel_d   = winner;
            data_d  = mux_out;
        end else if ((state_q == BUSY) && out_ready) begin
            state_d = IDLE;
        end
    end

    // State registers; ptr resets to 3 so requester 0 is scanned first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= SEL_W'(NUM_REQ - 1);
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    // Registered outputs.
    always_comb begin
        out_valid = (state_q == BUSY);
        out_data  = data_q;
        out_sel   = sel_q;
    end

endmodule
